// File: rtl/regfile_ctx_engine.sv
// Context save/restore engine for the register file.
// Walks register indices FIRST..LAST. In a save it streams each register out
// over a valid/ready channel. In a restore it writes each accepted stream word
// back into the register file. The core stalls its own register file writes
// while Busy_o is high.
module regfile_ctx_engine #(
    parameter int REG_WIDTH = 32,
    parameter int NUM_REGS  = 32,
    parameter bit SKIP_R0   = 1'b1,
    localparam int IW       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                 Clk_i,
    input  logic                 Rst_i,
    input  logic                 Start_Save_i,
    input  logic                 Start_Restore_i,
    input  logic                 Abort_i,
    output logic                 Busy_o,
    output logic                 Done_o,
    output logic [IW-1:0]        Rf_Ra_Sel_o,
    input  logic [REG_WIDTH-1:0] Rf_Data_i,
    output logic                 Rf_We_o,
    output logic [IW-1:0]        Rf_Rd_Sel_o,
    output logic [REG_WIDTH-1:0] Rf_Data_o,
    output logic [REG_WIDTH-1:0] Save_Data_o,
    output logic                 Save_Valid_o,
    input  logic                 Save_Ready_i,
    input  logic [REG_WIDTH-1:0] Restore_Data_i,
    input  logic                 Restore_Valid_i,
    output logic                 Restore_Ready_o
);

    // Register 0 is hard-wired to zero when SKIP_R0 is set, so the walk starts at 1.
    localparam logic [IW-1:0] FIRST = SKIP_R0 ? IW'(1) : '0;
    localparam logic [IW-1:0] LAST  = IW'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SAVE    = 2'd1,
        ST_RESTORE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [IW-1:0] r_idx;
    logic [IW-1:0] w_idx_nxt;

    // State and index registers; reset abandons any sequence in progress.
    always_ff @(posedge Clk_i) begin
        if (Rst_i) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Next-state logic and combinational handshake/register-file outputs.
    always_comb begin
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        Busy_o          = 1'b0;
        Done_o          = 1'b0;
        Rf_Ra_Sel_o     = '0;
        Rf_We_o         = 1'b0;
        Rf_Rd_Sel_o     = '0;
        Rf_Data_o       = '0;
        Save_Data_o     = '0;
        Save_Valid_o    = 1'b0;
        Restore_Ready_o = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // Save takes priority when both starts arrive together.
                if (Start_Save_i) begin
                    w_state_nxt = ST_SAVE;
                    w_idx_nxt   = FIRST;
                end else if (Start_Restore_i) begin
                    w_state_nxt = ST_RESTORE;
                    w_idx_nxt   = FIRST;
                end
            end

            ST_SAVE: begin
                Busy_o       = 1'b1;
                Rf_Ra_Sel_o  = r_idx;
                Save_Data_o  = Rf_Data_i;
                Save_Valid_o = !Abort_i;
                if (Abort_i) begin
                    w_state_nxt = ST_IDLE;
                end else if (Save_Ready_i) begin
                    if (r_idx == LAST) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_idx_nxt = r_idx + IW'(1);
                    end
                end
            end

            ST_RESTORE: begin
                Busy_o          = 1'b1;
                Restore_Ready_o = !Abort_i;
                if (Abort_i) begin
                    w_state_nxt = ST_IDLE;
                end else if (Restore_Valid_i) begin
                    // Write strobe only in the handshake cycle; the file captures at this edge.
                    Rf_We_o     = 1'b1;
                    Rf_Rd_Sel_o = r_idx;
                    Rf_Data_o   = Restore_Data_i;
                    if (r_idx == LAST) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_idx_nxt = r_idx + IW'(1);
                    end
                end
            end

            ST_DONE: begin
                Done_o      = 1'b1;
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_regfile_ctx_engine.sv
// Testbench for regfile_ctx_engine: a cycle table, hand-written corner
// sequences and randomized save/restore runs checked against a queue-based
// model. The bench also plays the register file (async read, write at edge).
module tb_regfile_ctx_engine;

    localparam int RW = 32;
    localparam int NR = 32;
    localparam int IW = 5;

    logic          Clk = 1'b0;
    logic          Rst;
    logic          Start_Save_i, Start_Restore_i, Abort_i;
    logic          Busy_o, Done_o;
    logic [IW-1:0] Rf_Ra_Sel_o, Rf_Rd_Sel_o;
    logic [RW-1:0] Rf_Data_i, Rf_Data_o;
    logic          Rf_We_o;
    logic [RW-1:0] Save_Data_o;
    logic          Save_Valid_o, Save_Ready_i;
    logic [RW-1:0] Restore_Data_i;
    logic          Restore_Valid_i, Restore_Ready_o;

    logic [RW-1:0] rf [NR];

    int n_cmp = 0;
    int n_err = 0;

    assign Rf_Data_i = rf[Rf_Ra_Sel_o];

    always #5 Clk = ~Clk;

    regfile_ctx_engine #(.REG_WIDTH(RW), .NUM_REGS(NR), .SKIP_R0(1'b1)) dut (
        .Clk_i(Clk), .Rst_i(Rst),
        .Start_Save_i(Start_Save_i), .Start_Restore_i(Start_Restore_i), .Abort_i(Abort_i),
        .Busy_o(Busy_o), .Done_o(Done_o),
        .Rf_Ra_Sel_o(Rf_Ra_Sel_o), .Rf_Data_i(Rf_Data_i),
        .Rf_We_o(Rf_We_o), .Rf_Rd_Sel_o(Rf_Rd_Sel_o), .Rf_Data_o(Rf_Data_o),
        .Save_Data_o(Save_Data_o), .Save_Valid_o(Save_Valid_o), .Save_Ready_i(Save_Ready_i),
        .Restore_Data_i(Restore_Data_i), .Restore_Valid_i(Restore_Valid_i),
        .Restore_Ready_o(Restore_Ready_o)
    );

    typedef struct {
        logic          ss, sr, ab, srdy, rv;
        logic [RW-1:0] rdata;
        logic          busy, done, sv, rr, we;
        logic [IW-1:0] ra, rd;
        logic [RW-1:0] sdata, wdata;
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic settle();
        #2;
    endtask

    // Finish the current cycle: emulate the register file write, then move to the next negedge.
    task automatic adv();
        logic          w;
        logic [IW-1:0] a;
        logic [RW-1:0] d;
        #1;
        w = Rf_We_o;
        a = Rf_Rd_Sel_o;
        d = Rf_Data_o;
        @(posedge Clk);
        if (w) rf[a] = d;
        @(negedge Clk);
    endtask

    task automatic idle_inputs();
        Start_Save_i = 0; Start_Restore_i = 0; Abort_i = 0;
        Save_Ready_i = 0; Restore_Valid_i = 0; Restore_Data_i = '0;
    endtask

    task automatic preload_pattern();
        for (int i = 0; i < NR; i++) rf[i] = (i == 0) ? 32'h0 : 32'h1000 + i;
    endtask

    function automatic vec_t mk(input logic ss, sr, ab, srdy, rv, input logic [RW-1:0] rdata,
                                input logic busy, done, sv, rr, we,
                                input logic [IW-1:0] ra, rd, input logic [RW-1:0] sdata, wdata);
        vec_t v;
        v.ss = ss; v.sr = sr; v.ab = ab; v.srdy = srdy; v.rv = rv; v.rdata = rdata;
        v.busy = busy; v.done = done; v.sv = sv; v.rr = rr; v.we = we;
        v.ra = ra; v.rd = rd; v.sdata = sdata; v.wdata = wdata;
        return v;
    endfunction

    // Randomized save: expected stream is simply registers 1..31 in order.
    task automatic run_save();
        logic [RW-1:0] q[$];
        int            eidx;
        logic          prev_stall;
        logic [IW-1:0] prev_ra;
        logic [RW-1:0] prev_data;
        logic          finished;
        for (int i = 1; i < NR; i++) q.push_back(rf[i]);
        eidx = 1; prev_stall = 0; prev_ra = '0; prev_data = '0; finished = 0;
        idle_inputs();
        Start_Save_i = 1; Start_Restore_i = 1'($urandom_range(0, 1));
        settle(); adv();
        Start_Save_i = 0;
        for (int c = 0; c < 400 && !finished; c++) begin
            Save_Ready_i    = ($urandom_range(0, 2) != 0);
            Start_Restore_i = 1'($urandom_range(0, 1));
            settle();
            if (q.size() == 0) begin
                chk("rsave_done", Done_o, 1);
                chk("rsave_done_busy", Busy_o, 0);
                finished = 1;
            end else begin
                chk("rsave_valid", Save_Valid_o, 1);
                chk("rsave_done_early", Done_o, 0);
                chk("rsave_no_rr", Restore_Ready_o, 0);
                chk("rsave_no_we", Rf_We_o, 0);
                if (prev_stall) begin
                    chk("rsave_stall_ra", Rf_Ra_Sel_o, prev_ra);
                    chk("rsave_stall_data", Save_Data_o, prev_data);
                end
                prev_stall = Save_Valid_o && !Save_Ready_i;
                prev_ra = Rf_Ra_Sel_o; prev_data = Save_Data_o;
                if (Save_Valid_o && Save_Ready_i) begin
                    chk("rsave_ra", Rf_Ra_Sel_o, eidx);
                    chk("rsave_data", Save_Data_o, q.pop_front());
                    eidx++;
                end
            end
            adv();
        end
        if (!finished) chk("rsave_timeout", 1, 0);
        idle_inputs(); settle(); chk("rsave_idle_after", Busy_o, 0); adv();
    endtask

    // Randomized restore: expected file image = old image with 1..31 replaced by the stream.
    task automatic run_restore(input bit pattern);
        logic [RW-1:0] d[$];
        logic [RW-1:0] e [NR];
        int            eidx, nwe;
        logic          finished;
        for (int i = 0; i < NR; i++) e[i] = rf[i];
        for (int i = 1; i < NR; i++) begin
            d.push_back(pattern ? 32'hA5A5_0000 + i : $urandom());
            e[i] = d[i-1];
        end
        eidx = 1; nwe = 0; finished = 0;
        idle_inputs();
        Start_Restore_i = 1;
        settle(); adv();
        Start_Restore_i = 0;
        for (int c = 0; c < 400 && !finished; c++) begin
            Restore_Valid_i = (d.size() != 0) && ($urandom_range(0, 2) != 0);
            Restore_Data_i  = Restore_Valid_i ? d[0] : $urandom();
            Start_Save_i    = 1'($urandom_range(0, 1));
            settle();
            if (d.size() == 0) begin
                chk("rrest_done", Done_o, 1);
                chk("rrest_done_we", Rf_We_o, 0);
                finished = 1;
            end else begin
                chk("rrest_ready", Restore_Ready_o, 1);
                chk("rrest_done_early", Done_o, 0);
                chk("rrest_no_sv", Save_Valid_o, 0);
                chk("rrest_we", Rf_We_o, Restore_Valid_i);
                if (Rf_We_o) begin
                    nwe++;
                    chk("rrest_rd", Rf_Rd_Sel_o, eidx);
                    chk("rrest_wdata", Rf_Data_o, d.pop_front());
                    eidx++;
                end
            end
            adv();
        end
        if (!finished) chk("rrest_timeout", 1, 0);
        chk("rrest_we_count", nwe, NR - 1);
        for (int i = 0; i < NR; i++) chk($sformatf("rrest_rf%0d", i), rf[i], e[i]);
        idle_inputs(); settle(); chk("rrest_idle_after", Busy_o, 0); adv();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        Rst = 1;
        preload_pattern();
        @(negedge Clk);
        settle(); adv();
        settle();
        chk("rst_busy", Busy_o, 0);
        chk("rst_done", Done_o, 0);
        chk("rst_sv", Save_Valid_o, 0);
        chk("rst_rr", Restore_Ready_o, 0);
        chk("rst_we", Rf_We_o, 0);
        chk("rst_ra", Rf_Ra_Sel_o, 0);
        chk("rst_rd", Rf_Rd_Sel_o, 0);
        chk("rst_wdata", Rf_Data_o, 0);
        adv();
        Rst = 0;

        // ---- Cycle table: dual start, stalls, ignored start, aborts, short restore ----
        //            ss sr ab rdy rv rdata          busy dn sv rr we ra rd sdata       wdata
        tbl[0]  = mk(0, 0, 0, 0, 0, 32'h0,           0, 0, 0, 0, 0, 0, 0, 32'h0,      32'h0);
        tbl[1]  = mk(1, 1, 0, 0, 0, 32'h0,           0, 0, 0, 0, 0, 0, 0, 32'h0,      32'h0);
        tbl[2]  = mk(0, 1, 0, 0, 0, 32'h0,           1, 0, 1, 0, 0, 1, 0, 32'h1001,   32'h0);
        tbl[3]  = mk(0, 0, 0, 1, 0, 32'h0,           1, 0, 1, 0, 0, 1, 0, 32'h1001,   32'h0);
        tbl[4]  = mk(0, 0, 0, 0, 0, 32'h0,           1, 0, 1, 0, 0, 2, 0, 32'h1002,   32'h0);
        tbl[5]  = mk(0, 1, 0, 0, 0, 32'h0,           1, 0, 1, 0, 0, 2, 0, 32'h1002,   32'h0);
        tbl[6]  = mk(0, 0, 0, 1, 0, 32'h0,           1, 0, 1, 0, 0, 2, 0, 32'h1002,   32'h0);
        tbl[7]  = mk(0, 0, 1, 1, 0, 32'h0,           1, 0, 0, 0, 0, 3, 0, 32'h1003,   32'h0);
        tbl[8]  = mk(0, 0, 0, 1, 0, 32'h0,           0, 0, 0, 0, 0, 0, 0, 32'h0,      32'h0);
        tbl[9]  = mk(1, 0, 0, 0, 0, 32'h0,           0, 0, 0, 0, 0, 0, 0, 32'h0,      32'h0);
        tbl[10] = mk(0, 0, 0, 1, 0, 32'h0,           1, 0, 1, 0, 0, 1, 0, 32'h1001,   32'h0);
        tbl[11] = mk(0, 0, 1, 1, 0, 32'h0,           1, 0, 0, 0, 0, 2, 0, 32'h1002,   32'h0);
        tbl[12] = mk(0, 1, 0, 0, 0, 32'h0,           0, 0, 0, 0, 0, 0, 0, 32'h0,      32'h0);
        tbl[13] = mk(0, 0, 0, 0, 0, 32'h0,           1, 0, 0, 1, 0, 0, 0, 32'h0,      32'h0);
        tbl[14] = mk(0, 0, 0, 0, 1, 32'hBEEF_0001,   1, 0, 0, 1, 1, 0, 1, 32'h0,      32'hBEEF_0001);
        tbl[15] = mk(0, 0, 1, 0, 1, 32'h1234_5678,   1, 0, 0, 0, 0, 0, 0, 32'h0,      32'h0);
        tbl[16] = mk(0, 0, 1, 0, 1, 32'h1234_5678,   0, 0, 0, 0, 0, 0, 0, 32'h0,      32'h0);
        for (int r = 0; r < 17; r++) begin
            Start_Save_i = tbl[r].ss; Start_Restore_i = tbl[r].sr; Abort_i = tbl[r].ab;
            Save_Ready_i = tbl[r].srdy; Restore_Valid_i = tbl[r].rv; Restore_Data_i = tbl[r].rdata;
            settle();
            chk($sformatf("tbl%0d_busy", r), Busy_o, tbl[r].busy);
            chk($sformatf("tbl%0d_done", r), Done_o, tbl[r].done);
            chk($sformatf("tbl%0d_sv", r), Save_Valid_o, tbl[r].sv);
            chk($sformatf("tbl%0d_rr", r), Restore_Ready_o, tbl[r].rr);
            chk($sformatf("tbl%0d_we", r), Rf_We_o, tbl[r].we);
            chk($sformatf("tbl%0d_ra", r), Rf_Ra_Sel_o, tbl[r].ra);
            chk($sformatf("tbl%0d_rd", r), Rf_Rd_Sel_o, tbl[r].rd);
            chk($sformatf("tbl%0d_sdata", r), Save_Data_o, tbl[r].sdata);
            chk($sformatf("tbl%0d_wdata", r), Rf_Data_o, tbl[r].wdata);
            adv();
        end
        idle_inputs();
        chk("tbl_rf1_written", rf[1], 32'hBEEF_0001);
        chk("tbl_rf2_untouched", rf[2], 32'h1002);

        // ---- Full save, ready held high: 31 back-to-back beats then one Done cycle ----
        preload_pattern();
        Start_Save_i = 1; settle(); adv();
        Start_Save_i = 0; Save_Ready_i = 1;
        for (int i = 1; i < NR; i++) begin
            settle();
            chk("full_busy", Busy_o, 1);
            chk("full_sv", Save_Valid_o, 1);
            chk("full_ra", Rf_Ra_Sel_o, i);
            chk("full_data", Save_Data_o, 32'h1000 + i);
            chk("full_done_early", Done_o, 0);
            chk("full_no_we", Rf_We_o, 0);
            adv();
        end
        Start_Restore_i = 1;
        settle();
        chk("full_done", Done_o, 1);
        chk("full_done_busy", Busy_o, 0);
        chk("full_done_sv", Save_Valid_o, 0);
        adv();
        Start_Restore_i = 0;
        settle();
        chk("full_after_done", Done_o, 0);
        chk("full_after_busy", Busy_o, 0);
        chk("full_after_rr", Restore_Ready_o, 0);
        adv();
        idle_inputs();

        // ---- Abort after the fifth beat, then restart from index 1 ----
        Start_Save_i = 1; settle(); adv();
        Start_Save_i = 0; Save_Ready_i = 1;
        for (int i = 1; i <= 5; i++) begin
            settle();
            chk("abort_beat_ra", Rf_Ra_Sel_o, i);
            chk("abort_beat_sv", Save_Valid_o, 1);
            adv();
        end
        Abort_i = 1;
        settle();
        chk("abort_sv_gated", Save_Valid_o, 0);
        chk("abort_ra_held", Rf_Ra_Sel_o, 6);
        adv();
        Abort_i = 0;
        for (int k = 0; k < 2; k++) begin
            settle();
            chk("abort_busy", Busy_o, 0);
            chk("abort_no_done", Done_o, 0);
            chk("abort_sv", Save_Valid_o, 0);
            adv();
        end
        Start_Save_i = 1; settle(); adv();
        Start_Save_i = 0;
        settle();
        chk("restart_ra", Rf_Ra_Sel_o, 1);
        chk("restart_data", Save_Data_o, 32'h1001);
        adv();
        Abort_i = 1; settle(); adv();
        idle_inputs();

        // ---- Reset in the middle of a restore after 10 writes ----
        preload_pattern();
        Start_Restore_i = 1; settle(); adv();
        Start_Restore_i = 0;
        for (int i = 1; i <= 10; i++) begin
            Restore_Valid_i = 1; Restore_Data_i = 32'hA5A5_0000 + i;
            settle();
            chk("rstmid_we", Rf_We_o, 1);
            chk("rstmid_rd", Rf_Rd_Sel_o, i);
            adv();
        end
        Restore_Valid_i = 0; Rst = 1;
        settle(); adv();
        Rst = 0; Restore_Valid_i = 1; Restore_Data_i = 32'hDEAD_BEEF;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("rstmid_busy", Busy_o, 0);
            chk("rstmid_we_off", Rf_We_o, 0);
            chk("rstmid_rr", Restore_Ready_o, 0);
            chk("rstmid_done", Done_o, 0);
            adv();
        end
        idle_inputs();
        for (int i = 1; i < NR; i++)
            chk($sformatf("rstmid_rf%0d", i), rf[i], (i <= 10) ? 32'hA5A5_0000 + i : 32'h1000 + i);

        // ---- Randomized runs against the queue model ----
        for (int i = 0; i < NR; i++) rf[i] = $urandom();
        run_restore(1'b1);
        for (int it = 0; it < 6; it++) begin
            for (int i = 0; i < NR; i++) rf[i] = $urandom();
            if ($urandom_range(0, 1) == 0) run_save();
            else run_restore(1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
